calc_cmd_issuer: RTL

- Command-side front end for the accumulator calculator datapath (16-bit operand, 4-bit opcode, 32-bit accumulator, 2-bit error code).
- Accepts opcode/operand commands over a valid/ready handshake and issues each one to the datapath as a single-cycle opcode pulse.
- Captures the resulting accumulator value and error code, and returns them over a valid/ready response channel.
- Maintains completed-command and error counters for the debug/status path.

---
 rtl/calc_cmd_issuer_pkg.sv | 46 ++++
 rtl/calc_cmd_issuer_if.sv | 31 +++
 rtl/calc_cmd_issuer_stat_ctr.sv | 41 ++++
 rtl/calc_cmd_issuer.sv | 106 ++++++++++
 4 files changed

// File: rtl/calc_cmd_issuer_pkg.sv
// Shared types and constants for the accumulator calculator command issuer.
// Opcode/error encodings match the datapath; widths are fixed by the datapath.
package calc_pkg;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;
    localparam int OP_W   = 4;
    localparam int ERR_W  = 2;
    localparam int CNT_W  = 16;
    localparam int LAT_W  = 4;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_ILL  = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h3;
    localparam logic [OP_W-1:0] OP_MUL  = 4'h4;
    localparam logic [OP_W-1:0] OP_DIV  = 4'h5;
    localparam logic [OP_W-1:0] OP_MOD  = 4'h6;
    localparam logic [OP_W-1:0] OP_OR   = 4'h7;
    localparam logic [OP_W-1:0] OP_AND  = 4'h8;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h9;
    localparam logic [OP_W-1:0] OP_NAND = 4'hA;
    localparam logic [OP_W-1:0] OP_NOR  = 4'hB;
    localparam logic [OP_W-1:0] OP_XNOR = 4'hC;
    localparam logic [OP_W-1:0] OP_NOT  = 4'hD;
    localparam logic [OP_W-1:0] OP_PRE  = 4'hE;
    localparam logic [OP_W-1:0] OP_RST  = 4'hF;

    localparam logic [ERR_W-1:0] ERR_OK   = 2'b00;
    localparam logic [ERR_W-1:0] ERR_OVF  = 2'b01;
    localparam logic [ERR_W-1:0] ERR_DIV0 = 2'b10;
    localparam logic [ERR_W-1:0] ERR_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2,
        RESP   = 2'd3
    } state_e;

    // The illegal opcode is answered locally and never reaches the datapath.
    function automatic logic is_illegal(input logic [OP_W-1:0] op);
        return op == OP_ILL;
    endfunction

endpackage

// File: rtl/calc_cmd_issuer_if.sv
// Command, response and datapath signals of the issuer, grouped as one bus.
// slave = issuer side, master = host plus datapath side.
interface calc_cmd_issuer_if;
    import calc_pkg::*;

    logic              CMD_VALID;
    logic              CMD_READY;
    logic [OP_W-1:0]   CMD_OP;
    logic [DATA_W-1:0] CMD_IN;

    logic              RSP_VALID;
    logic              RSP_READY;
    logic [ACC_W-1:0]  RSP_OUT;
    logic [ERR_W-1:0]  RSP_ERR;

    logic [OP_W-1:0]   ALU_OP;
    logic [DATA_W-1:0] ALU_IN;
    logic [ACC_W-1:0]  ALU_OUT;
    logic [ERR_W-1:0]  ALU_ERR;

    modport slave (
        input  CMD_VALID, CMD_OP, CMD_IN, RSP_READY, ALU_OUT, ALU_ERR,
        output CMD_READY, RSP_VALID, RSP_OUT, RSP_ERR, ALU_OP, ALU_IN
    );

    modport master (
        output CMD_VALID, CMD_OP, CMD_IN, RSP_READY, ALU_OUT, ALU_ERR,
        input  CMD_READY, RSP_VALID, RSP_OUT, RSP_ERR, ALU_OP, ALU_IN
    );

endinterface

// File: rtl/calc_cmd_issuer_stat_ctr.sv
// Status counters: completed responses (wrapping) and error responses (saturating).
module calc_stat_ctr
    import calc_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_i,
    input  logic                 err_i,
    output logic [CNT_W-1:0]     cmd_cnt_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    logic [CNT_W-1:0]     cmd_cnt_q, cmd_cnt_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        cmd_cnt_d = cmd_cnt_q;
        err_cnt_d = err_cnt_q;
        if (inc_i) begin
            cmd_cnt_d = cmd_cnt_q + CNT_W'(1);
            if (err_i && (err_cnt_q != '1))
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            cmd_cnt_q <= cmd_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign cmd_cnt_o = cmd_cnt_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: rtl/calc_cmd_issuer.sv
// One-in-flight command issuer: pulses each opcode to the datapath for a single
// cycle, waits ALU_LAT cycles, then returns accumulator and error code.
module calc_cmd_issuer
    import calc_pkg::*;
#(
    parameter int ALU_LAT   = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    calc_cmd_issuer_if.slave     bus,
    output logic [CNT_W-1:0]     CMD_CNT,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    state_e            state_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [ACC_W-1:0]  rsp_out_q;
    logic [ERR_W-1:0]  rsp_err_q;
    logic [OP_W-1:0]   alu_op_q;
    logic [DATA_W-1:0] alu_in_q;
    logic              nop_q;
    logic [LAT_W-1:0]  lat_q;
    logic              rsp_done;

    assign rsp_done = (state_q == RESP) && bus.RSP_READY;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_out_q   <= '0;
            rsp_err_q   <= ERR_OK;
            alu_op_q    <= OP_NOP;
            alu_in_q    <= '0;
            nop_q       <= 1'b0;
            lat_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.CMD_VALID && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        if (is_illegal(bus.CMD_OP)) begin
                            // Answered without touching the datapath; RSP_OUT keeps last capture.
                            rsp_err_q   <= ERR_ILL;
                            rsp_valid_q <= 1'b1;
                            state_q     <= RESP;
                        end else begin
                            alu_op_q <= bus.CMD_OP;
                            alu_in_q <= bus.CMD_IN;
                            nop_q    <= (bus.CMD_OP == OP_NOP);
                            state_q  <= ISSUE;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    alu_op_q <= OP_NOP;
                    lat_q    <= LAT_W'(ALU_LAT);
                    state_q  <= SETTLE;
                end
                SETTLE: begin
                    if (lat_q == LAT_W'(1)) begin
                        rsp_out_q   <= bus.ALU_OUT;
                        // A no-op never executed, so any stale datapath error is not its own.
                        rsp_err_q   <= nop_q ? ERR_OK : bus.ALU_ERR;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.CMD_READY = cmd_ready_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_OUT   = rsp_out_q;
    assign bus.RSP_ERR   = rsp_err_q;
    assign bus.ALU_OP    = alu_op_q;
    assign bus.ALU_IN    = alu_in_q;

    calc_stat_ctr #(
        .ERR_CNT_W (ERR_CNT_W)
    ) u_stat (
        .clk       (CLK),
        .rst_n     (RST_N),
        .inc_i     (rsp_done),
        .err_i     (rsp_err_q != ERR_OK),
        .cmd_cnt_o (CMD_CNT),
        .err_cnt_o (ERR_CNT)
    );

endmodule
